note_highway: RTL and testbench

NOTE_HIGHWAY -- requirements
Module: note_highway

---
 rtl/note_highway.sv | 190 +++++++++++++++++++
 tb/tb_note_highway.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/note_highway.sv
// Note highway: per-lane song shift registers scored against player hits, plus a
// renderer that streams a snapshot of the visible rows as coloured boxes.
module note_highway #(
  parameter int LANES = 3,
  parameter int SONG_LEN = 115,
  parameter int ROWS = 4,
  parameter int BOX_W = 30,
  parameter int BOX_H = 30,
  parameter int X0 = 0,
  parameter int Y0 = 60,
  parameter int SCORE_W = 8,
  parameter logic [LANES*SONG_LEN-1:0] SONG_INIT = '0,
  parameter logic [2:0] NOTE_COLOUR = 3'b101,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               song_load,
  input  logic               shift_song,
  input  logic [LANES-1:0]   hit,
  input  logic               draw_start,
  output logic               draw_busy,
  output logic               draw_done,
  output logic [8:0]         vga_x,
  output logic [7:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] combo,
  output logic               song_done
);
  localparam int STEP_W = $clog2(SONG_LEN + 1);
  localparam int HIT_W = $clog2(LANES + 1);
  localparam int SUM_W = SCORE_W + HIT_W;
  localparam int PX_W = $clog2(BOX_W + 1);
  localparam int PY_W = $clog2(BOX_H + 1);
  localparam int LANE_W = $clog2(LANES + 1);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [LANES*SONG_LEN-1:0] song, song_shifted;
  logic [STEP_W-1:0]         step;
  logic [LANES-1:0]          bottom, missed;
  logic [HIT_W-1:0]          hit_count;
  logic [SUM_W-1:0]          score_sum;
  logic [SCORE_W-1:0]        score_next, combo_next;

  always_comb begin
    song_shifted = '0;
    bottom = '0;
    hit_count = '0;
    for (int l = 0; l < LANES; l++) begin
      song_shifted[l*SONG_LEN +: SONG_LEN] = song[l*SONG_LEN +: SONG_LEN] >> 1;
      bottom[l] = song[l*SONG_LEN];
      hit_count = hit_count + HIT_W'(song[l*SONG_LEN] & hit[l]);
    end
    missed = bottom & ~hit;
    score_sum = SUM_W'(score) + SUM_W'(hit_count);
    score_next = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    // Hits on empty lanes are ignored: only noted lanes can extend or break the combo.
    combo_next = combo;
    if (missed != '0) combo_next = '0;
    else if (bottom != '0 && combo != SCORE_MAX) combo_next = combo + SCORE_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || song_load) begin
      song      <= SONG_INIT;
      step      <= '0;
      score     <= '0;
      combo     <= '0;
      song_done <= 1'b0;
    end else if (shift_song && !song_done) begin
      song  <= song_shifted;
      score <= score_next;
      combo <= combo_next;
      step  <= step + STEP_W'(1);
      if (step == STEP_W'(SONG_LEN - 1)) song_done <= 1'b1;
    end
  end

  // draw_start is a one-shot request: it is accepted only in IDLE and never queued;
  // vga_plot marks each valid pixel and the consumer has no back-pressure.
  typedef enum logic [1:0] {IDLE, DRAW, DONE} draw_state_t;
  draw_state_t state, state_next;

  logic [PX_W-1:0]       px, px_n;
  logic [PY_W-1:0]       py, py_n;
  logic [LANE_W-1:0]     lane_c, lane_n;
  logic [ROW_W-1:0]      row_c, row_n;
  logic [LANES*ROWS-1:0] snap, fresh_snap, pick_snap;
  logic                  last_pixel, advance, pixel_on;
  logic [8:0]            x_next;
  logic [7:0]            y_next;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign last_pixel = (px == PX_W'(BOX_W - 1)) && (py == PY_W'(BOX_H - 1)) &&
                      (lane_c == LANE_W'(LANES - 1)) && (row_c == ROW_W'(ROWS - 1));

  always_comb begin
    state_next = state;
    advance = 1'b0;
    case (state)
      IDLE: if (draw_start) begin
        state_next = DRAW;
        advance = 1'b1;
      end
      DRAW: begin
        if (last_pixel) state_next = DONE;
        else advance = 1'b1;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign draw_busy = (state == DRAW);
  assign draw_done = (state == DONE);

  // Counters always name the pixel currently on the vga outputs; *_n is the one to present next.
  always_comb begin
    fresh_snap = '0;
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < ROWS; r++)
        fresh_snap[l*ROWS + r] = song[l*SONG_LEN + r];
    pick_snap = (state == IDLE) ? fresh_snap : snap;

    px_n = '0;
    py_n = '0;
    lane_n = '0;
    row_n = '0;
    if (state != IDLE) begin
      px_n = px;
      py_n = py;
      lane_n = lane_c;
      row_n = row_c;
      if (px != PX_W'(BOX_W - 1)) px_n = px + PX_W'(1);
      else begin
        px_n = '0;
        if (py != PY_W'(BOX_H - 1)) py_n = py + PY_W'(1);
        else begin
          py_n = '0;
          if (lane_c != LANE_W'(LANES - 1)) lane_n = lane_c + LANE_W'(1);
          else begin
            lane_n = '0;
            row_n = row_c + ROW_W'(1);
          end
        end
      end
    end

    pixel_on = 1'b0;
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < ROWS; r++)
        if (lane_n == LANE_W'(l) && row_n == ROW_W'(r)) pixel_on = pick_snap[l*ROWS + r];

    x_next = 9'(11'(X0) + 11'(lane_n) * 11'(BOX_W) + 11'(px_n));
    y_next = 8'(11'(Y0) + (11'(ROWS - 1) - 11'(row_n)) * 11'(BOX_H) + 11'(py_n));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      px         <= '0;
      py         <= '0;
      lane_c     <= '0;
      row_c      <= '0;
      snap       <= '0;
    end else begin
      vga_plot <= advance;
      if (advance) begin
        px         <= px_n;
        py         <= py_n;
        lane_c     <= lane_n;
        row_c      <= row_n;
        vga_x      <= x_next;
        vga_y      <= y_next;
        vga_colour <= pixel_on ? NOTE_COLOUR : BG_COLOUR;
      end
      if (state == IDLE && draw_start) snap <= fresh_snap;
    end
  end
endmodule

// File: tb/tb_note_highway.sv
// Bench for note_highway: vector table for scoring, saturation run, small-geometry
// frames with mid-draw conflicts, and random play checked against a queue model.
module tb_note_highway;
  logic clock = 1'b0;
  logic reset, g_reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoring instance (3 lanes, 4 steps).
  logic s_load, s_shift, s_start; logic [2:0] s_hit;
  logic s_busy, s_dpulse, s_plot, s_done; logic [8:0] s_x; logic [7:0] s_y; logic [2:0] s_col;
  logic [7:0] s_score, s_combo;
  note_highway #(.LANES(3), .SONG_LEN(4), .SONG_INIT(12'h013)) dut_s (
    .clock(clock), .reset(reset), .song_load(s_load), .shift_song(s_shift), .hit(s_hit),
    .draw_start(s_start), .draw_busy(s_busy), .draw_done(s_dpulse), .vga_x(s_x), .vga_y(s_y),
    .vga_colour(s_col), .vga_plot(s_plot), .score(s_score), .combo(s_combo), .song_done(s_done));

  // Saturation instance (2-bit score, every step fully noted).
  logic t_load, t_shift, t_start; logic [2:0] t_hit;
  logic t_busy, t_dpulse, t_plot, t_done; logic [8:0] t_x; logic [7:0] t_y; logic [2:0] t_col;
  logic [1:0] t_score, t_combo;
  note_highway #(.LANES(3), .SONG_LEN(6), .SCORE_W(2), .SONG_INIT(18'h3FFFF)) dut_t (
    .clock(clock), .reset(reset), .song_load(t_load), .shift_song(t_shift), .hit(t_hit),
    .draw_start(t_start), .draw_busy(t_busy), .draw_done(t_dpulse), .vga_x(t_x), .vga_y(t_y),
    .vga_colour(t_col), .vga_plot(t_plot), .score(t_score), .combo(t_combo), .song_done(t_done));

  // Small geometry instance: lane0 = 0001, lane1 = 0010.
  logic g_load, g_shift, g_start; logic [1:0] g_hit;
  logic g_busy, g_dpulse, g_plot, g_done; logic [8:0] g_x; logic [7:0] g_y; logic [2:0] g_col;
  logic [7:0] g_score, g_combo;
  note_highway #(.LANES(2), .SONG_LEN(4), .ROWS(2), .BOX_W(2), .BOX_H(2), .X0(0), .Y0(60),
                 .SONG_INIT(8'h21)) dut_g (
    .clock(clock), .reset(g_reset), .song_load(g_load), .shift_song(g_shift), .hit(g_hit),
    .draw_start(g_start), .draw_busy(g_busy), .draw_done(g_dpulse), .vga_x(g_x), .vga_y(g_y),
    .vga_colour(g_col), .vga_plot(g_plot), .score(g_score), .combo(g_combo), .song_done(g_done));

  // Default-parameter instance for random play and a full-size frame.
  localparam logic [344:0] R_INIT = {23{15'h5a3c}};
  logic r_load, r_shift, r_start; logic [2:0] r_hit;
  logic r_busy, r_dpulse, r_plot, r_done; logic [8:0] r_x; logic [7:0] r_y; logic [2:0] r_col;
  logic [7:0] r_score, r_combo;
  note_highway #(.SONG_INIT(R_INIT)) dut_r (
    .clock(clock), .reset(reset), .song_load(r_load), .shift_song(r_shift), .hit(r_hit),
    .draw_start(r_start), .draw_busy(r_busy), .draw_done(r_dpulse), .vga_x(r_x), .vga_y(r_y),
    .vga_colour(r_col), .vga_plot(r_plot), .score(r_score), .combo(r_combo), .song_done(r_done));

  // Reference model: each lane is a queue of upcoming notes, front = due now.
  logic [344:0] r_init_v;
  bit m_q[3][$];
  int m_score, m_combo, m_steps;
  bit m_done;

  task automatic model_load();
    for (int l = 0; l < 3; l++) begin
      m_q[l].delete();
      for (int k = 0; k < 115; k++) m_q[l].push_back(r_init_v[l*115 + k]);
    end
    m_score = 0; m_combo = 0; m_steps = 0; m_done = 0;
  endtask

  task automatic model_edge(input logic load, input logic shift, input logic [2:0] h);
    int hits, noted, misses;
    hits = 0; noted = 0; misses = 0;
    if (load) model_load();
    else if (shift && !m_done) begin
      for (int l = 0; l < 3; l++)
        if (m_q[l][0]) begin
          noted++;
          if (h[l]) hits++; else misses++;
        end
      m_score = (m_score + hits > 255) ? 255 : m_score + hits;
      if (noted > 0) m_combo = (misses > 0) ? 0 : ((m_combo == 255) ? 255 : m_combo + 1);
      for (int l = 0; l < 3; l++) begin
        void'(m_q[l].pop_front());
        m_q[l].push_back(1'b0);
      end
      m_steps++;
      if (m_steps == 115) m_done = 1;
    end
  endtask

  function automatic logic [19:0] g_pixel(input int k, input logic [3:0] snap);
    int b, p, row, lane;
    b = k / 4; p = k % 4; row = b / 2; lane = b % 2;
    return {9'(lane*2 + p%2), 8'(60 + (1-row)*2 + p/2), snap[lane*2 + row] ? 3'b101 : 3'b000};
  endfunction

  // Starts a frame at the current negedge and watches 20 cycles; snap index = lane*2+row.
  task automatic g_frame(input string name, input logic [3:0] snap, input int shift_at,
                         input int restart_at, input int reset_at, input int exp_plots);
    logic exp_plot;
    g_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      exp_plot = (c <= exp_plots);
      check($sformatf("%s plot c%0d", name, c), g_plot, exp_plot);
      check($sformatf("%s busy c%0d", name, c), g_busy, exp_plot);
      check($sformatf("%s done c%0d", name, c), g_dpulse, (exp_plots == 16 && c == 17));
      if (exp_plot && g_plot)
        check($sformatf("%s pixel %0d", name, c-1), {g_x, g_y, g_col}, g_pixel(c-1, snap));
      if (exp_plots == 16 && c == 20)
        check($sformatf("%s held xy", name), {g_x, g_y}, {9'd3, 8'd61});
      g_start = (c == restart_at);
      g_shift = (c == shift_at);
      g_reset = (c == reset_at);
    end
    g_start = 1'b0; g_shift = 1'b0; g_reset = 1'b0;
  endtask

  typedef struct {
    logic load; logic shift; logic [2:0] hit; int score; int combo; logic done;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 3'b000, 0, 0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 3'b011, 2, 1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 3'b000, 2, 0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 3'b111, 2, 0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 3'b111, 2, 0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 3'b111, 2, 0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 3'b011, 0, 0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 3'b011, 2, 1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 3'b001, 3, 2, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 3'b111, 3, 2, 1'b0};

    r_init_v = R_INIT;
    model_load();
    {s_load, s_shift, s_start, s_hit} = '0;
    {t_load, t_shift, t_start, t_hit} = '0;
    {g_load, g_shift, g_start, g_hit} = '0;
    {r_load, r_shift, r_start, r_hit} = '0;
    reset = 1'b1; g_reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset r outputs", {r_score, r_combo, r_done, r_plot, r_busy, r_dpulse}, 0);
    check("reset r vga", {r_x, r_y, r_col}, 0);
    check("reset g outputs", {g_plot, g_busy, g_dpulse, g_x, g_y, g_col}, 0);
    reset = 1'b0; g_reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      s_load = vecs[i].load; s_shift = vecs[i].shift; s_hit = vecs[i].hit;
      @(negedge clock);
      check($sformatf("vec%0d score", i), s_score, vecs[i].score);
      check($sformatf("vec%0d combo", i), s_combo, vecs[i].combo);
      check($sformatf("vec%0d song_done", i), s_done, vecs[i].done);
    end
    s_load = 1'b0; s_shift = 1'b0; s_hit = '0;

    for (int k = 1; k <= 5; k++) begin
      t_shift = 1'b1; t_hit = 3'b111;
      @(negedge clock);
      t_shift = 1'b0;
      check($sformatf("sat score %0d", k), t_score, (3*k > 3) ? 3 : 3*k);
      check($sformatf("sat combo %0d", k), t_combo, (k > 3) ? 3 : k);
      @(negedge clock);
    end
    t_hit = '0;

    g_frame("frame_a", 4'b1001, 3, 5, 0, 16);
    g_frame("frame_b", 4'b0100, 0, 0, 7, 7);
    g_frame("frame_c", 4'b1001, 0, 0, 0, 16);

    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      check("rand score", r_score, m_score);
      check("rand combo", r_combo, m_combo);
      check("rand song_done", r_done, m_done);
      r_load = ($urandom_range(0, 149) == 0);
      r_shift = ($urandom_range(0, 4) < 3);
      r_hit = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      model_edge(r_load, r_shift, r_hit);
    end
    r_load = 1'b0; r_shift = 1'b0;
    @(negedge clock);
    check("rand final score", r_score, m_score);
    check("rand final combo", r_combo, m_combo);

    r_start = 1'b1;
    for (int c = 1; c <= 10802; c++) begin
      int k, b, p, row, lane;
      @(negedge clock);
      r_start = 1'b0;
      check("big plot", r_plot, c <= 10800);
      check("big done", r_dpulse, c == 10801);
      if (c <= 10800) begin
        k = c - 1; b = k / 900; p = k % 900; row = b / 3; lane = b % 3;
        check("big pixel", {r_x, r_y, r_col},
              {9'(lane*30 + p%30), 8'(60 + (3-row)*30 + p/30), m_q[lane][row] ? 3'b101 : 3'b000});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
